// File: rtl/crc16_engine.sv
// crc16_engine
//   Shared CRC-16/CCITT-FALSE engine (poly 0x1021, init 0xFFFF, MSB-first,
//   no reflection, no final XOR) arbitrated between the seal register and
//   the CPU CRC peripheral slot. The seal side owns the engine while
//   seal_lock is high. Otherwise only CPU strobes are honoured.
//
//   Default build: each byte is shifted in bit-serially over 8 SHIFT cycles.
//   Optional macro CRC16_FAST_EN: each byte is folded in one cycle with an
//   unrolled network. crc_value results are identical in both builds.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   seal_lock           seal FSM owns the engine
//   seal_init/feed/byte seal strobes (init to INIT, fold seal_byte)
//   cpu_data_wr/in      CPU write of a byte to CRC_DATA
//   cpu_ctrl_wr/in      CPU write to CRC_CTRL, {clr_dropped, crc_reset}
//   crc_busy            engine busy (includes the accept cycle combinationally)
//   crc_value           running 16-bit remainder
//   cpu_status          {13'b0, dropped, busy, 1'b0, crc_value}
module crc16_engine #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seal_lock,
  input  logic        seal_init,
  input  logic        seal_feed,
  input  logic [7:0]  seal_byte,
  input  logic        cpu_data_wr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_ctrl_wr,
  input  logic [1:0]  cpu_ctrl_in,
  output logic        crc_busy,
  output logic [15:0] crc_value,
  output logic [31:0] cpu_status
);

  // One MSB-first step of the polynomial division.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  logic       init_req;
  logic       feed_req;
  logic [7:0] feed_byte;
  logic       cpu_violation;
  logic       drop_set;
  logic       drop_clr;
  logic       accept;
  logic       dropped;
  logic [15:0] crc;
  logic [15:0] crc_next;

  // Source select. While the seal side holds its lock, every CPU data write
  // or CRC reset is refused and recorded as a violation.
  always_comb begin
    init_req      = 1'b0;
    feed_req      = 1'b0;
    feed_byte     = 8'h00;
    cpu_violation = 1'b0;
    if (seal_lock) begin
      init_req      = seal_init;
      feed_req      = seal_feed;
      feed_byte     = seal_byte;
      cpu_violation = cpu_data_wr | (cpu_ctrl_wr & cpu_ctrl_in[0]);
    end else begin
      init_req  = cpu_ctrl_wr & cpu_ctrl_in[0];
      feed_req  = cpu_data_wr;
      feed_byte = cpu_data_in;
    end
  end

  // Clearing the sticky flag is not an engine access, so it is honoured
  // regardless of who owns the engine.
  assign drop_clr = cpu_ctrl_wr & cpu_ctrl_in[1];

`ifdef CRC16_FAST_EN

  // Whole byte folded in one cycle: eight chained division steps.
  function automatic logic [15:0] crc_fold_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = crc_step(r, d[i]);
    end
    return r;
  endfunction

  // The engine is never busy across cycles, so every feed is accepted and
  // the only way the CPU can lose a write is by colliding with the lock.
  assign accept   = feed_req;
  assign drop_set = cpu_violation;
  assign crc_busy = accept;

  // Init and feed together fold the byte into INIT rather than the old value.
  always_comb begin
    crc_next = init_req ? INIT : crc;
    if (accept) begin
      crc_next = crc_fold_byte(crc_next, feed_byte);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= INIT;
    end else begin
      crc <= crc_next;
    end
  end

`else

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_cnt_next;
  logic [7:0]  shift_byte;
  logic [7:0]  shift_byte_next;

  // A feed is only taken while idle. The accept cycle already reports busy
  // so a client that registered its pulse sees busy on the following cycle.
  assign accept   = feed_req & (state == IDLE);
  assign crc_busy = (state == SHIFT) | accept;

  // CPU bytes arriving mid-shift are lost and flagged; seal bytes arriving
  // mid-shift are a seal protocol error and are silently ignored.
  assign drop_set = cpu_violation | (~seal_lock & cpu_data_wr & (state == SHIFT));

  // State register: bit_cnt runs 1..8 in SHIFT and rests at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      crc        <= INIT;
      shift_byte <= 8'h00;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      crc        <= crc_next;
      shift_byte <= shift_byte_next;
    end
  end

  // Next-state logic. The accept cycle only latches the byte (and INIT when
  // requested); the eight division steps happen in the SHIFT cycles, so the
  // result is settled when busy drops. Init in SHIFT abandons the byte.
  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    crc_next        = crc;
    shift_byte_next = shift_byte;
    case (state)
      IDLE: begin
        if (init_req) begin
          crc_next = INIT;
        end
        if (accept) begin
          shift_byte_next = feed_byte;
          bit_cnt_next    = 4'd1;
          state_next      = SHIFT;
        end
      end
      SHIFT: begin
        if (init_req) begin
          crc_next     = INIT;
          bit_cnt_next = 4'd0;
          state_next   = IDLE;
        end else begin
          crc_next        = crc_step(crc, shift_byte[7]);
          shift_byte_next = {shift_byte[6:0], 1'b0};
          if (bit_cnt == 4'd8) begin
            bit_cnt_next = 4'd0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
    endcase
  end

`endif

  // Sticky collision flag; a simultaneous set and clear leaves it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped <= 1'b0;
    end else if (drop_set) begin
      dropped <= 1'b1;
    end else if (drop_clr) begin
      dropped <= 1'b0;
    end
  end

  assign crc_value  = crc;
  assign cpu_status = {13'b0, dropped, crc_busy, 1'b0, crc};

endmodule

// File: tb/tb_crc16_engine.sv
// tb_crc16_engine
//   Self-checking bench for crc16_engine. A byte-level reference model runs
//   in a compare process on every falling edge; directed sequences add
//   hand-computed literal expectations, then randomized traffic follows.
module tb_crc16_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seal_lock = 1'b0;
  logic        seal_init = 1'b0;
  logic        seal_feed = 1'b0;
  logic [7:0]  seal_byte = 8'h00;
  logic        cpu_data_wr = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic        cpu_ctrl_wr = 1'b0;
  logic [1:0]  cpu_ctrl_in = 2'b00;
  logic        crc_busy;
  logic [15:0] crc_value;
  logic [31:0] cpu_status;

  int checks = 0;
  int errors = 0;

`ifdef CRC16_FAST_EN
  localparam int BUSY_LEN = 1;
`else
  localparam int BUSY_LEN = 9;
`endif

  crc16_engine dut (
    .clk         (clk),
    .rst         (rst),
    .seal_lock   (seal_lock),
    .seal_init   (seal_init),
    .seal_feed   (seal_feed),
    .seal_byte   (seal_byte),
    .cpu_data_wr (cpu_data_wr),
    .cpu_data_in (cpu_data_in),
    .cpu_ctrl_wr (cpu_ctrl_wr),
    .cpu_ctrl_in (cpu_ctrl_in),
    .crc_busy    (crc_busy),
    .crc_value   (crc_value),
    .cpu_status  (cpu_status)
  );

  always #5 clk = ~clk;

  // Reference CRC of one byte: XOR byte into the top, divide 8 times.
  function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state: visible remainder, busy cycles still to run, result due
  // when they run out, and the sticky dropped flag.
  logic [15:0] m_crc = 16'hFFFF;
  logic [15:0] m_pending = 16'hFFFF;
  int          m_rem = 0;
  logic        m_drop = 1'b0;
  bit          m_valid = 1'b0;

  always @(negedge clk) begin : compare
    logic        locked, init, feed, busy_now, dset, dclr;
    logic [7:0]  b;
    logic [15:0] base;
    if (rst) begin
      m_crc   = 16'hFFFF;
      m_rem   = 0;
      m_drop  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      locked = seal_lock;
      init   = locked ? seal_init : (cpu_ctrl_wr & cpu_ctrl_in[0]);
      feed   = locked ? seal_feed : cpu_data_wr;
      b      = locked ? seal_byte : cpu_data_in;
`ifdef CRC16_FAST_EN
      busy_now = feed;
      dset     = locked & (cpu_data_wr | (cpu_ctrl_wr & cpu_ctrl_in[0]));
`else
      busy_now = (m_rem > 0) || feed;
      dset     = locked ? (cpu_data_wr | (cpu_ctrl_wr & cpu_ctrl_in[0]))
                        : (cpu_data_wr && (m_rem > 0));
`endif
      dclr = cpu_ctrl_wr & cpu_ctrl_in[1];
      checkOutput("busy", 32'(crc_busy), 32'(busy_now));
      checkOutput("status_hi", 32'(cpu_status[31:16]), 32'({13'b0, m_drop, busy_now, 1'b0}));
      if (m_rem == 0) begin
        checkOutput("crc_value", 32'(crc_value), 32'(m_crc));
        checkOutput("status_crc", 32'(cpu_status[15:0]), 32'(m_crc));
      end
      if (dset) m_drop = 1'b1;
      else if (dclr) m_drop = 1'b0;
`ifdef CRC16_FAST_EN
      base  = init ? 16'hFFFF : m_crc;
      m_crc = feed ? crcByte(base, b) : base;
`else
      if (m_rem > 0) begin
        if (init) begin
          m_crc = 16'hFFFF;
          m_rem = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) m_crc = m_pending;
        end
      end else begin
        base = init ? 16'hFFFF : m_crc;
        if (feed) begin
          m_pending = crcByte(base, b);
          m_rem     = 8;
        end
        m_crc = base;
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearStrobes();
    seal_init   = 1'b0;
    seal_feed   = 1'b0;
    cpu_data_wr = 1'b0;
    cpu_ctrl_wr = 1'b0;
    cpu_ctrl_in = 2'b00;
  endtask

  // One-cycle CPU pulse on data and/or control.
  task automatic applyStimulus(input logic dwr, input logic [7:0] d, input logic cwr, input logic [1:0] c);
    cpu_data_wr = dwr;
    cpu_data_in = d;
    cpu_ctrl_wr = cwr;
    cpu_ctrl_in = c;
    step();
    clearStrobes();
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    #1;
    while (crc_busy && n < 30) begin
      step();
      n++;
      #1;
    end
    if (crc_busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // CPU byte write, counting the cycles busy stays high from the write on.
  task automatic feedCounted(input logic [7:0] b, output int n);
    cpu_data_wr = 1'b1;
    cpu_data_in = b;
    #1;
    n = 0;
    while (crc_busy && n < 30) begin
      n++;
      step();
      cpu_data_wr = 1'b0;
      #1;
    end
    cpu_data_wr = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_crc;
    clearStrobes();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checkOutput("reset_crc", 32'(crc_value), 32'h0000FFFF);
    checkOutput("reset_busy", 32'(crc_busy), 32'h0);
    checkOutput("reset_status", cpu_status, 32'h0000FFFF);

    // "123456789" check string, one byte at a time with an idle gap.
    for (int i = 0; i < 9; i++) begin
      waitIdle("ascii_wait");
      feedCounted(8'(8'h31 + i), n);
      checkOutput("ascii_busy_len", 32'(n), 32'(BUSY_LEN));
      step();
    end
    waitIdle("ascii_final");
    checkOutput("ascii_crc", 32'(crc_value), 32'h000029B1);

    // Seal owns the engine; a colliding CPU write is refused and flagged.
    seal_lock   = 1'b1;
    seal_init   = 1'b1;
    seal_feed   = 1'b1;
    seal_byte   = 8'h00;
    cpu_data_wr = 1'b1;
    cpu_data_in = 8'h55;
    step();
    clearStrobes();
    waitIdle("seal_wait");
    checkOutput("seal_crc", 32'(crc_value), 32'h0000E1F0);
    checkOutput("seal_dropped", 32'(cpu_status[18]), 32'h1);
    seal_lock = 1'b0;
    step();
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b10);
    #1;
    checkOutput("clr_dropped", 32'(cpu_status[18]), 32'h0);
    checkOutput("unlock_keeps_crc", 32'(crc_value), 32'h0000E1F0);

    // Init four cycles into a byte abandons it.
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b01);
    cpu_data_wr = 1'b1;
    cpu_data_in = 8'h31;
    step();
    clearStrobes();
    step();
    step();
    step();
    cpu_ctrl_wr = 1'b1;
    cpu_ctrl_in = 2'b01;
    step();
    clearStrobes();
    #1;
    checkOutput("abort_busy", 32'(crc_busy), 32'h0);
    checkOutput("abort_crc", 32'(crc_value), 32'h0000FFFF);
    applyStimulus(1'b1, 8'h00, 1'b0, 2'b00);
    waitIdle("abort_refeed");
    checkOutput("abort_refeed_crc", 32'(crc_value), 32'h0000E1F0);

    // Second CPU byte three cycles after the first.
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b01);
    cpu_data_wr = 1'b1;
    cpu_data_in = 8'h31;
    step();
    clearStrobes();
    step();
    step();
    cpu_data_wr = 1'b1;
    cpu_data_in = 8'h32;
    step();
    clearStrobes();
    #1;
`ifdef CRC16_FAST_EN
    checkOutput("busy_feed_dropped", 32'(cpu_status[18]), 32'h0);
    exp_crc = crcByte(crcByte(16'hFFFF, 8'h31), 8'h32);
`else
    checkOutput("busy_feed_dropped", 32'(cpu_status[18]), 32'h1);
    exp_crc = crcByte(16'hFFFF, 8'h31);
`endif
    waitIdle("busy_feed_wait");
    checkOutput("busy_feed_crc", 32'(crc_value), 32'(exp_crc));
    applyStimulus(1'b0, 8'h00, 1'b1, 2'b10);
    #1;
    checkOutput("busy_feed_clr", 32'(cpu_status[18]), 32'h0);

    // Init and feed together on top of earlier data start from INIT.
    applyStimulus(1'b1, 8'h00, 1'b1, 2'b01);
    waitIdle("init_feed_wait");
    checkOutput("init_feed_crc", 32'(crc_value), 32'h0000E1F0);

    // Reset in the middle of a byte.
    applyStimulus(1'b1, 8'hA5, 1'b0, 2'b00);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_crc", 32'(crc_value), 32'h0000FFFF);
    checkOutput("rst_mid_busy", 32'(crc_busy), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) seal_lock = ~seal_lock;
      rst         = ($urandom_range(0, 249) == 0);
      seal_init   = ($urandom_range(0, 15) == 0);
      seal_feed   = ($urandom_range(0, 5) == 0);
      seal_byte   = 8'($urandom);
      cpu_data_wr = ($urandom_range(0, 5) == 0);
      cpu_data_in = 8'($urandom);
      cpu_ctrl_wr = ($urandom_range(0, 9) == 0);
      cpu_ctrl_in = 2'($urandom);
      step();
    end
    clearStrobes();
    rst = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
